hw_loop_controller: RTL and testbench

//  Zero-overhead hardware-loop sequencer for the single-cycle MIPS core with nesting support.

---
 rtl/hw_loop_pkg.sv | 12 +
 rtl/hw_loop_stack.sv | 46 ++++
 rtl/hw_loop_controller.sv | 93 +++++++++
 tb/tb_hw_loop_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hw_loop_pkg.sv
// Shared types for the hardware-loop sequencer: loop stack entry and LOOP opcode.
package hw_loop_pkg;
  localparam int LOOP_ADDR_W = 32;
  localparam int LOOP_CNT_W  = 32;
  localparam logic [5:0] LOOP_OPCODE = 6'h3F;

  typedef struct packed {
    logic [LOOP_ADDR_W-1:0] start_addr;
    logic [LOOP_ADDR_W-1:0] end_addr;
    logic [LOOP_CNT_W-1:0]  count;
  } loop_entry_t;
endpackage

// File: rtl/hw_loop_stack.sv
// DEPTH-entry LIFO of loop entries; only the top entry is visible and decrementable.
module hw_loop_stack
  import hw_loop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        dec_top,
  input  loop_entry_t push_entry,
  output loop_entry_t top_entry,
  output logic [DW-1:0] depth,
  output logic        full,
  output logic        empty
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loop_entry_t [DEPTH-1:0] mem;
  logic [DW-1:0] cnt;
  logic [IW-1:0] tos_idx, push_idx;

  assign full     = (cnt == DW'(DEPTH));
  assign empty    = (cnt == '0);
  assign depth    = cnt;
  assign tos_idx  = IW'(cnt - 1'b1);
  assign push_idx = IW'(cnt);
  assign top_entry = empty ? '0 : mem[tos_idx];

  // Push, pop and decrement are mutually exclusive; priority order is arbitrary.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      mem <= '0;
    end else if (push && !full) begin
      mem[push_idx] <= push_entry;
      cnt           <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end else if (dec_top && !empty) begin
      mem[tos_idx].count <= mem[tos_idx].count - 1'b1;
    end
  end
endmodule

// File: rtl/hw_loop_controller.sv
// Zero-overhead nested hardware-loop sequencer: watches pc against the top loop's
// end address and issues combinational back-edge redirects.
module hw_loop_controller
  import hw_loop_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = LOOP_ADDR_W,
  parameter int CNT_W  = LOOP_CNT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       advance,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       loop_init,
  input  logic [CNT_W-1:0]           init_count,
  input  logic [ADDR_W-1:0]          init_start,
  input  logic [ADDR_W-1:0]          init_end,
  output logic                       redirect_valid,
  output logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       overflow_err,
  output logic                       nest_err
);
  loop_entry_t push_entry, tos;
  logic push, pop, dec_top, full, empty;
  logic set_ovf, set_nest, end_match;
  logic [ADDR_W-1:0] tos_start, tos_end;
  logic [CNT_W-1:0]  tos_count;

  hw_loop_stack #(.DEPTH(DEPTH)) u_stack (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .dec_top    (dec_top),
    .push_entry (push_entry),
    .top_entry  (tos),
    .depth      (depth),
    .full       (full),
    .empty      (empty)
  );

  assign push_entry = '{start_addr: LOOP_ADDR_W'(init_start),
                        end_addr:   LOOP_ADDR_W'(init_end),
                        count:      LOOP_CNT_W'(init_count)};
  assign tos_start = tos.start_addr[ADDR_W-1:0];
  assign tos_end   = tos.end_addr[ADDR_W-1:0];
  assign tos_count = tos.count[CNT_W-1:0];
  assign end_match = !empty && (pc == tos_end);
  assign busy      = !empty;

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    push           = 1'b0;
    pop            = 1'b0;
    dec_top        = 1'b0;
    set_ovf        = 1'b0;
    set_nest       = 1'b0;
    if (!reset && advance) begin
      if (end_match) begin
        // A LOOP sitting on the active end address is malformed; the back-edge wins.
        set_nest = loop_init;
        if (tos_count > CNT_W'(1)) begin
          redirect_valid = 1'b1;
          redirect_pc    = tos_start;
          dec_top        = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end else if (loop_init) begin
        if (init_count == '0) begin
          redirect_valid = 1'b1;
          redirect_pc    = init_end + ADDR_W'(4);
        end else if (init_count != CNT_W'(1)) begin
          if (full) set_ovf = 1'b1;
          else      push    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_err <= 1'b0;
      nest_err     <= 1'b0;
    end else begin
      if (set_ovf)  overflow_err <= 1'b1;
      if (set_nest) nest_err     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hw_loop_controller.sv
// Directed bench for hw_loop_controller with a queue-based loop-stack model checked every cycle.
module tb_hw_loop_controller;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b0;
  logic [31:0] pc = '0;
  logic        loop_init = 1'b0;
  logic [31:0] init_count = '0, init_start = '0, init_end = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  depth;
  logic        busy, overflow_err, nest_err;

  hw_loop_controller #(.DEPTH(DEPTH), .ADDR_W(32), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .advance(advance), .pc(pc),
    .loop_init(loop_init), .init_count(init_count), .init_start(init_start),
    .init_end(init_end), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .depth(depth), .busy(busy), .overflow_err(overflow_err), .nest_err(nest_err)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, rcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the loop stack as queues, state changes applied at each rising edge.
  logic [31:0] m_start[$], m_end[$], m_cnt[$];
  bit m_ovf = 0, m_nest = 0, started = 0;

  function automatic void model_out(output bit rv, output logic [31:0] rpc);
    rv = 0; rpc = '0;
    if (!reset && advance) begin
      if (m_end.size() > 0 && pc == m_end[$]) begin
        if (m_cnt[$] > 1) begin rv = 1; rpc = m_start[$]; end
      end else if (loop_init && init_count == 0) begin
        rv = 1; rpc = init_end + 32'd4;
      end
    end
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_start.delete(); m_end.delete(); m_cnt.delete();
      m_ovf = 0; m_nest = 0; started = 1;
    end else if (started && advance) begin
      if (m_end.size() > 0 && pc == m_end[$]) begin
        if (loop_init) m_nest = 1;
        if (m_cnt[$] > 1) m_cnt[m_cnt.size()-1] = m_cnt[$] - 1;
        else begin
          void'(m_start.pop_back()); void'(m_end.pop_back()); void'(m_cnt.pop_back());
        end
      end else if (loop_init && init_count >= 2) begin
        if (m_end.size() == DEPTH) m_ovf = 1;
        else begin
          m_start.push_back(init_start); m_end.push_back(init_end); m_cnt.push_back(init_count);
        end
      end
    end
  end

  bit          e_rv;
  logic [31:0] e_rpc;
  always @(negedge clock) begin
    if (started) begin
      model_out(e_rv, e_rpc);
      chk("m_redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
      chk("m_redirect_pc", redirect_pc, e_rpc);
      chk("m_depth", {29'b0, depth}, m_end.size());
      chk("m_busy", {31'b0, busy}, {31'b0, m_end.size() != 0});
      chk("m_overflow_err", {31'b0, overflow_err}, {31'b0, m_ovf});
      chk("m_nest_err", {31'b0, nest_err}, {31'b0, m_nest});
      if (redirect_valid === 1'b1) rcount++;
    end
  end

  task automatic set_in(input bit a, input logic [31:0] p, input bit li,
                        input logic [31:0] c, input logic [31:0] s, input logic [31:0] e);
    advance = a; pc = p; loop_init = li; init_count = c; init_start = s; init_end = e;
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  logic [31:0] li_pc[8], li_cnt[8], li_start[8], li_end[8];
  int n_li = 0, peak = 0;

  // Walks a program, following the model's expected next PC, until exit_pc.
  task automatic run_prog(input logic [31:0] entry, input logic [31:0] exit_pc, input int budget);
    logic [31:0] p, c, s, e, rpc;
    bit li, rv;
    int n;
    p = entry; n = 0;
    while (p != exit_pc && n < budget) begin
      li = 0; c = '0; s = '0; e = '0;
      for (int k = 0; k < n_li; k++)
        if (li_pc[k] == p) begin li = 1; c = li_cnt[k]; s = li_start[k]; e = li_end[k]; end
      set_in(1, p, li, c, s, e);
      #1;
      if (int'(depth) > peak) peak = int'(depth);
      model_out(rv, rpc);
      p = rv ? rpc : p + 32'd4;
      tick();
      n++;
    end
    total++;
    if (p != exit_pc) begin
      bad++;
      $display("FAIL prog_timeout: pc %h expected exit %h", p, exit_pc);
    end
  endtask

  initial begin
    tick(); tick();
    // Reset suppresses redirects even with a count=0 LOOP presented.
    set_in(1, 32'h1C, 1, 0, 32'h20, 32'h20);
    #1 chk("reset_rv", {31'b0, redirect_valid}, 32'd0);
    tick();
    reset = 1'b0;
    set_in(0, 32'h0, 0, 0, 0, 0);
    #1;
    chk("rst_depth", {29'b0, depth}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_err}, 32'd0);
    chk("rst_nest", {31'b0, nest_err}, 32'd0);
    tick();

    // Test 1: count=3 single loop.
    rcount = 0;
    set_in(1, 32'h1C, 1, 3, 32'h20, 32'h24);
    tick();
    chk("t1_depth_push", {29'b0, depth}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h20, 0, 0, 0, 0); tick();
      set_in(1, 32'h24, 0, 0, 0, 0);
      #1 chk("t1_rv", {31'b0, redirect_valid}, (i < 2) ? 32'd1 : 32'd0);
      if (i < 2) chk("t1_rpc", redirect_pc, 32'h20);
      tick();
    end
    chk("t1_depth_end", {29'b0, depth}, 32'd0);
    chk("t1_redirects", rcount, 32'd2);

    // Test 2: count=0 skips the body, count=1 runs it once.
    set_in(1, 32'h1C, 1, 0, 32'h20, 32'h20);
    #1;
    chk("t2_rv0", {31'b0, redirect_valid}, 32'd1);
    chk("t2_rpc0", redirect_pc, 32'h24);
    tick();
    chk("t2_depth0", {29'b0, depth}, 32'd0);
    set_in(1, 32'h1C, 1, 1, 32'h20, 32'h20);
    #1 chk("t2_rv1", {31'b0, redirect_valid}, 32'd0);
    tick();
    chk("t2_depth1", {29'b0, depth}, 32'd0);

    // Test 3: outer count=2 around inner count=3.
    li_pc[0] = 32'h1C; li_cnt[0] = 2; li_start[0] = 32'h20; li_end[0] = 32'h30;
    li_pc[1] = 32'h20; li_cnt[1] = 3; li_start[1] = 32'h24; li_end[1] = 32'h28;
    n_li = 2; peak = 0; rcount = 0;
    run_prog(32'h1C, 32'h34, 100);
    chk("t3_redirects", rcount, 32'd5);
    chk("t3_peak", peak, 32'd2);
    chk("t3_depth_end", {29'b0, depth}, 32'd0);

    // Test 4: five nested count=5 loops into a 4-deep stack.
    for (int k = 0; k < 5; k++) begin
      set_in(1, 32'h100 + 4*k, 1, 5, 32'h104 + 4*k, 32'h140 - 4*k);
      tick();
      chk("t4_depth", {29'b0, depth}, (k < 4) ? k + 1 : 4);
    end
    chk("t4_ovf", {31'b0, overflow_err}, 32'd1);
    for (logic [31:0] p = 32'h114; p <= 32'h130; p += 4) begin
      set_in(1, p, 0, 0, 0, 0);
      #1;
      if (p == 32'h130) chk("t4_5th_no_rv", {31'b0, redirect_valid}, 32'd0);
      tick();
    end

    // Test 5: stalls at the active end address, then four back-edges and a pop.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 32'h134, 0, 0, 0, 0);
      #1 chk("t5_stall_rv", {31'b0, redirect_valid}, 32'd0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h134, 0, 0, 0, 0);
      #1 chk("t5_rv", {31'b0, redirect_valid}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("t5_rpc", redirect_pc, 32'h110);
      tick();
    end
    chk("t5_depth", {29'b0, depth}, 32'd3);

    // LOOP at the active end address: back-edge taken, init ignored, nest_err set.
    set_in(1, 32'h138, 1, 5, 32'h13C, 32'h138);
    #1;
    chk("nest_rv", {31'b0, redirect_valid}, 32'd1);
    chk("nest_rpc", redirect_pc, 32'h10C);
    tick();
    chk("nest_err", {31'b0, nest_err}, 32'd1);
    chk("nest_depth", {29'b0, depth}, 32'd3);

    // Test 6: one-cycle reset mid-loop.
    reset = 1'b1;
    set_in(1, 32'h138, 0, 0, 0, 0);
    #1 chk("t6_rst_rv", {31'b0, redirect_valid}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_depth", {29'b0, depth}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_ovf", {31'b0, overflow_err}, 32'd0);
    chk("t6_nest", {31'b0, nest_err}, 32'd0);
    chk("t6_rv", {31'b0, redirect_valid}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
